layer_output_demux: RTL and testbench

Collects the serial 8-bit neuron results produced by the MAC array for one layer and routes the assembled vector to its destination. A hidden-layer pass is packed into the 30-byte hidden register image that feeds back to the network input selector. An output-layer pass is packed into a 10-byte result vector with an argmax class index, which is held for the host under a valid/ack handshake. It sits between the neuron datapath and both the hidden register and the host result port.

---
 rtl/layer_output_demux.sv | 147 ++++++++++++++
 tb/tb_layer_output_demux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_output_demux.sv
// layer_output_demux
// Collects one layer's worth of serial neuron results and routes the assembled
// vector either to the hidden register image (hidden pass) or to the host
// result port with an argmax class index (output pass).
//
// Ports:
//   clk, rst       : single clock, synchronous active-high reset
//   start          : begin collecting a layer (sampled only in IDLE)
//   layer_sel      : captured with start; 0 = hidden pass, 1 = output pass
//   neuron_valid   : neuron_data valid this cycle
//   neuron_data    : next neuron value, neuron 0 first (signed W-bit)
//   neuron_ready   : block accepts neuron_data this cycle
//   reg_hid        : hidden vector, neuron k at [W*k +: W]
//   hid_load       : one-cycle pulse when reg_hid has been updated
//   result         : output vector, same packing as reg_hid
//   result_class   : index of the maximum signed result
//   result_valid   : result/result_class valid and frozen until result_ack
//   result_ack     : host consumed the result
//   busy           : high in every state except IDLE
module layer_output_demux #(
    parameter int unsigned HID_N = 30,
    parameter int unsigned OUT_N = 10,
    parameter int unsigned W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               layer_sel,
    input  logic               neuron_valid,
    input  logic [W-1:0]       neuron_data,
    output logic               neuron_ready,
    output logic [HID_N*W-1:0] reg_hid,
    output logic               hid_load,
    output logic [OUT_N*W-1:0] result,
    output logic [3:0]         result_class,
    output logic               result_valid,
    input  logic               result_ack,
    output logic               busy
);

    localparam int unsigned CW = $clog2(HID_N);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT,
        WAIT_ACK
    } state_t;

    state_t              state, state_nxt;
    logic                mode;
    logic [CW-1:0]       count;
    logic [W-1:0]        shadow [HID_N];
    logic signed [W-1:0] max_val, max_nxt;
    logic [3:0]          max_idx, idx_nxt;
    logic                accept, last_byte;

    assign accept    = (state == COLLECT) && neuron_valid;
    assign last_byte = mode ? (count == CW'(OUT_N - 1)) : (count == CW'(HID_N - 1));

    // Running argmax; strict greater-than keeps the lowest index on ties,
    // and neuron 0 always seeds the maximum.
    always_comb begin
        max_nxt = max_val;
        idx_nxt = max_idx;
        if (count == '0 || $signed(neuron_data) > max_val) begin
            max_nxt = neuron_data;
            idx_nxt = count[3:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = COLLECT;
            COLLECT:  if (accept && last_byte) state_nxt = COMMIT;
            COMMIT:   state_nxt = mode ? WAIT_ACK : IDLE;
            WAIT_ACK: if (result_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        neuron_ready = (state == COLLECT);
        busy         = (state != IDLE);
        hid_load     = (state == COMMIT) && !mode;
        result_valid = ((state == COMMIT) && mode) || (state == WAIT_ACK);
    end

    // Datapath. The destination register is written on the same edge that
    // accepts the last byte (shadow merged with that byte), so the vector is
    // already visible during the COMMIT cycle alongside hid_load/result_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode         <= 1'b0;
            count        <= '0;
            max_val      <= '0;
            max_idx      <= '0;
            reg_hid      <= '0;
            result       <= '0;
            result_class <= '0;
            for (int unsigned k = 0; k < HID_N; k++) shadow[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode    <= layer_sel;
                        count   <= '0;
                        max_val <= '0;
                        max_idx <= '0;
                        for (int unsigned k = 0; k < HID_N; k++) shadow[k] <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        shadow[count] <= neuron_data;
                        count         <= count + 1'b1;
                        if (mode) begin
                            max_val <= max_nxt;
                            max_idx <= idx_nxt;
                        end
                        if (last_byte) begin
                            if (!mode) begin
                                for (int unsigned k = 0; k < HID_N; k++)
                                    reg_hid[W*k +: W] <= (CW'(k) == count) ? neuron_data : shadow[k];
                            end else begin
                                for (int unsigned k = 0; k < OUT_N; k++)
                                    result[W*k +: W] <= (CW'(k) == count) ? neuron_data : shadow[k];
                                result_class <= idx_nxt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_demux.sv
module tb_layer_output_demux;

    localparam int unsigned HID_N = 30;
    localparam int unsigned OUT_N = 10;
    localparam int unsigned W     = 8;

    logic               clk = 1'b0;
    logic               rst, start, layer_sel, neuron_valid, result_ack;
    logic [W-1:0]       neuron_data;
    logic               neuron_ready, hid_load, result_valid, busy;
    logic [HID_N*W-1:0] reg_hid;
    logic [OUT_N*W-1:0] result;
    logic [3:0]         result_class;

    layer_output_demux #(.HID_N(HID_N), .OUT_N(OUT_N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
        .neuron_valid(neuron_valid), .neuron_data(neuron_data),
        .neuron_ready(neuron_ready), .reg_hid(reg_hid), .hid_load(hid_load),
        .result(result), .result_class(result_class), .result_valid(result_valid),
        .result_ack(result_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                 is_out;
        int                 exp_cyc;
        logic [HID_N*W-1:0] vec;
        logic [3:0]         cls;
    } exp_t;

    exp_t               sb[$];
    int                 n_tests = 0;
    int                 n_fail  = 0;
    logic [OUT_N*W-1:0] exp_result = '0;
    logic [3:0]         exp_class  = '0;
    logic [W-1:0]       stim [HID_N];

    task automatic check(input string name, input logic [HID_N*W-1:0] act,
                         input logic [HID_N*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a vector.
    logic prev_rv = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_rv = 1'b0;
        end else begin
            if (hid_load === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_hid_load: got pulse at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("hid_kind", {239'd0, e.is_out}, '0);
                    check("hid_load_cycle", HID_N*W'(cyc), HID_N*W'(e.exp_cyc));
                    check("reg_hid", reg_hid, e.vec);
                    check("result_untouched", {160'd0, result}, {160'd0, exp_result});
                end
            end
            if (result_valid === 1'b1 && !prev_rv) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_result_valid: got rise at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    exp_result = e.vec[OUT_N*W-1:0];
                    exp_class  = e.cls;
                    check("result_kind", {239'd0, e.is_out}, {239'd0, 1'b1});
                    check("result_valid_cycle", HID_N*W'(cyc), HID_N*W'(e.exp_cyc));
                    check("result", {160'd0, result}, {160'd0, exp_result});
                    check("result_class", {236'd0, result_class}, {236'd0, exp_class});
                end
            end else if (result_valid === 1'b1) begin
                check("result_hold", {160'd0, result}, {160'd0, exp_result});
                check("result_class_hold", {236'd0, result_class}, {236'd0, exp_class});
            end
            prev_rv = result_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit sel);
        start = 1'b1; layer_sel = sel;
        tick();
        start = 1'b0; layer_sel = 1'b0;
        check("ready_after_start", {239'd0, neuron_ready}, {239'd0, 1'b1});
    endtask

    // Presents one byte and returns the cycle index following its acceptance.
    task automatic feed(input logic [W-1:0] b, output int acc_cyc);
        int g = 0;
        while (neuron_ready !== 1'b1 && g < 50) begin tick(); g++; end
        if (g >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL ready_timeout: got neuron_ready=0 expected 1");
        end
        neuron_valid = 1'b1; neuron_data = b;
        tick();
        acc_cyc = cyc;
        neuron_valid = 1'b0; neuron_data = 8'hAA;
    endtask

    // Runs a full pass from stim[]; returns in the COMMIT cycle.
    task automatic run_pass(input bit sel, input bit gapped, input int inject_at,
                            input logic [3:0] cls);
        int   n, ac;
        exp_t x;
        n = sel ? OUT_N : HID_N;
        do_start(sel);
        for (int i = 0; i < n; i++) begin
            if (i == inject_at) begin start = 1'b1; layer_sel = 1'b1; end
            feed(stim[i], ac);
            start = 1'b0; layer_sel = 1'b0;
            if (i == n - 1) begin
                x.is_out  = sel;
                x.exp_cyc = ac;
                x.vec     = '0;
                for (int k = 0; k < n; k++) x.vec[W*k +: W] = stim[k];
                x.cls     = cls;
                sb.push_back(x);
            end else if (gapped) begin
                tick();
            end
        end
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("rv_after_ack", {239'd0, result_valid}, '0);
        check("busy_after_ack", {239'd0, busy}, '0);
    endtask

    task automatic load_out(input logic [W*OUT_N-1:0] v);
        for (int k = 0; k < OUT_N; k++) stim[k] = v[W*(OUT_N-1-k) +: W];
    endtask

    initial begin
        int ac;
        rst = 1'b1; start = 1'b0; layer_sel = 1'b0; neuron_valid = 1'b0;
        neuron_data = '0; result_ack = 1'b0;
        tick(); tick();
        check("rst_neuron_ready", {239'd0, neuron_ready}, '0);
        check("rst_busy", {239'd0, busy}, '0);
        check("rst_hid_load", {239'd0, hid_load}, '0);
        check("rst_result_valid", {239'd0, result_valid}, '0);
        check("rst_reg_hid", reg_hid, '0);
        check("rst_result", {160'd0, result}, '0);
        check("rst_result_class", {236'd0, result_class}, '0);
        rst = 1'b0;
        tick();

        // Hidden pass, back-to-back 0x01..0x1E
        for (int k = 0; k < HID_N; k++) stim[k] = W'(k + 1);
        run_pass(1'b0, 1'b0, -1, 4'd0);
        check("reg_hid_lo", {232'd0, reg_hid[7:0]}, {232'd0, 8'h01});
        check("reg_hid_hi", {232'd0, reg_hid[239:232]}, {232'd0, 8'h1E});
        tick();
        check("idle_after_hidden", {239'd0, busy}, '0);

        // Ack with no result pending does nothing
        result_ack = 1'b1; tick(); result_ack = 1'b0;
        check("stray_ack_busy", {239'd0, busy}, '0);

        // Output pass with argmax tie and negative value
        load_out({8'h05, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h10, 8'hFF, 8'h20, 8'h30, 8'h40});
        run_pass(1'b1, 1'b0, -1, 4'd1);
        repeat (5) begin
            tick();
            check("rv_held", {239'd0, result_valid}, {239'd0, 1'b1});
        end
        ack_result();
        tick();

        // Gapped hidden pass, same bytes as the first pass
        for (int k = 0; k < HID_N; k++) stim[k] = W'(k + 1);
        run_pass(1'b0, 1'b1, -1, 4'd0);
        tick();

        // Data offered in IDLE is dropped
        neuron_valid = 1'b1; neuron_data = 8'h55; tick(); neuron_valid = 1'b0;
        check("idle_data_ignored", {239'd0, busy}, '0);

        // start with layer_sel=1 mid hidden pass is ignored
        for (int k = 0; k < HID_N; k++) stim[k] = W'(8'h80 + k);
        run_pass(1'b0, 1'b0, 5, 4'd0);
        tick();

        // Reset after 12 bytes of a hidden pass
        do_start(1'b0);
        for (int i = 0; i < 12; i++) feed(W'(8'hC0 + i), ac);
        rst = 1'b1;
        tick();
        check("midrst_busy", {239'd0, busy}, '0);
        check("midrst_ready", {239'd0, neuron_ready}, '0);
        check("midrst_reg_hid", reg_hid, '0);
        check("midrst_result", {160'd0, result}, '0);
        exp_result = '0; exp_class = '0;
        rst = 1'b0;
        tick();
        for (int k = 0; k < HID_N; k++) stim[k] = W'(8'hF0 - k);
        run_pass(1'b0, 1'b0, -1, 4'd0);
        tick();

        // All-negative output layer resolves to index 0
        for (int k = 0; k < OUT_N; k++) stim[k] = 8'h80;
        run_pass(1'b1, 1'b0, -1, 4'd0);
        tick();
        ack_result();

        // Strictly increasing values: maximum at the last index
        for (int k = 0; k < OUT_N; k++) stim[k] = W'(k);
        run_pass(1'b1, 1'b0, -1, 4'd9);
        tick();
        ack_result();
        tick(); tick();

        check("scoreboard_drained", HID_N*W'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
